// File: rtl/can_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_scheduler
// Purpose  : Arbitrates NUM_MB transmit mailboxes onto the single CAN
//            transmit engine. Owns the engine's startXmit handshake and
//            watches busy until completion or timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: CAN_SCHED_ABORT_EN
//   defined   - mb_abort[i] clears pending[i] unless mailbox i is in flight
//   undefined - mb_abort is ignored
// ----------------------------------------------------------------------------
// Ports
//   PCLK, PRESETn          clock, synchronous active-low reset
//   mb_load/mb_sel/mb_*    mailbox write port (frame id/data/DLC/format/type)
//   mb_abort               per-mailbox cancel request
//   bit_cfg                {quantaDiv, propQuanta, seg1Quanta}, taken at ARB
//   busy                   transmitter busy
//   startXmit              one-cycle start pulse to the transmitter
//   xmitdata..seg1Quanta   registered frame fields for the transmitter
//   mb_pending             per-mailbox unsent-frame flags
//   load_rej               pulse: load hit the in-flight mailbox
//   tx_done / tx_err       pulse: frame completed / busy timeout
//   tx_idx                 in-flight mailbox, valid with tx_done/tx_err
// ============================================================================
module can_tx_scheduler #(
    parameter int NUM_MB       = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      mb_load,
    input  logic [$clog2(NUM_MB)-1:0] mb_sel,
    input  logic [28:0]               mb_id,
    input  logic [63:0]               mb_data,
    input  logic [3:0]                mb_datalen,
    input  logic                      mb_format,
    input  logic [1:0]                mb_frametype,
    input  logic [NUM_MB-1:0]         mb_abort,
    input  logic [19:0]               bit_cfg,
    input  logic                      busy,
    output logic                      startXmit,
    output logic [63:0]               xmitdata,
    output logic [28:0]               id,
    output logic [3:0]                datalen,
    output logic                      format,
    output logic [1:0]                frameType,
    output logic [7:0]                quantaDiv,
    output logic [5:0]                propQuanta,
    output logic [5:0]                seg1Quanta,
    output logic [NUM_MB-1:0]         mb_pending,
    output logic                      load_rej,
    output logic                      tx_done,
    output logic                      tx_err,
    output logic [$clog2(NUM_MB)-1:0] tx_idx
);

    localparam int c_IDX_W = $clog2(NUM_MB);
    localparam int c_CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_IDX_W:0]   c_NUM_MB  = (c_IDX_W + 1)'(NUM_MB);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(BUSY_TIMEOUT);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_ARB       = 3'd1;
    localparam logic [2:0] c_S_START     = 3'd2;
    localparam logic [2:0] c_S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_S_WAIT_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_tx_idx;
    logic               r_start;
    logic [63:0]        r_xmitdata;
    logic [28:0]        r_id;
    logic [3:0]         r_datalen;
    logic               r_format;
    logic [1:0]         r_frametype;
    logic [7:0]         r_quantadiv;
    logic [5:0]         r_propquanta;
    logic [5:0]         r_seg1quanta;
    logic               r_load_rej;
    logic               r_tx_done;
    logic               r_tx_err;

    // Per-mailbox views, driven from g_mb
    logic [28:0]        w_mb_id   [NUM_MB];
    logic [63:0]        w_mb_data [NUM_MB];
    logic [3:0]         w_mb_dlc  [NUM_MB];
    logic               w_mb_fmt  [NUM_MB];
    logic [1:0]         w_mb_ft   [NUM_MB];
    logic [29:0]        w_key     [NUM_MB];
    logic [NUM_MB-1:0]  w_pending;

    logic               w_found;
    logic [c_IDX_W-1:0] w_win_idx;
    logic [29:0]        w_best_key;
    logic               w_flight_vld;
    logic [c_IDX_W-1:0] w_flight_idx;
    logic               w_sel_flight;
    logic               w_load_ok;
    logic               w_finish;

    // Lowest key wins; strict '<' while scanning upward keeps ties on the
    // lowest mailbox index.
    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_best_key = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (w_pending[i] && (!w_found || (w_key[i] < w_best_key))) begin
                w_found    = 1'b1;
                w_best_key = w_key[i];
                w_win_idx  = c_IDX_W'(i);
            end
        end
    end

    // During ARB the winner is already committed: its fields are latched at
    // the end of this cycle, so a load racing into it must be refused too.
    assign w_flight_vld = ((r_state == c_S_ARB) && w_found) ||
                          (r_state == c_S_START) ||
                          (r_state == c_S_WAIT_BUSY) ||
                          (r_state == c_S_WAIT_DONE);
    assign w_flight_idx = (r_state == c_S_ARB) ? w_win_idx : r_tx_idx;
    assign w_sel_flight = w_flight_vld && (mb_sel == w_flight_idx);
    assign w_load_ok    = mb_load && ({1'b0, mb_sel} < c_NUM_MB) && !w_sel_flight;
    assign w_finish     = ((r_state == c_S_WAIT_BUSY) && !busy && (r_cnt == c_TIMEOUT)) ||
                          ((r_state == c_S_WAIT_DONE) && !busy);

`ifndef CAN_SCHED_ABORT_EN
    logic w_abort_unused;
    assign w_abort_unused = ^mb_abort;
`endif

    for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_mb
        logic [28:0] r_mb_id;
        logic [63:0] r_mb_data;
        logic [3:0]  r_mb_dlc;
        logic        r_mb_fmt;
        logic [1:0]  r_mb_ft;
        logic        r_pend;
        logic        w_load_hit;
        logic        w_finish_hit;
        logic        w_abort_hit;

        assign w_load_hit   = w_load_ok && (mb_sel == c_IDX_W'(gi));
        assign w_finish_hit = w_finish && (r_tx_idx == c_IDX_W'(gi));
`ifdef CAN_SCHED_ABORT_EN
        assign w_abort_hit  = mb_abort[gi] &&
                              !(w_flight_vld && (w_flight_idx == c_IDX_W'(gi)));
`else
        assign w_abort_hit  = 1'b0;
`endif

        // Load has priority over abort; completion and load never coincide
        // on one mailbox because loads into the in-flight mailbox are refused.
        always_ff @(posedge PCLK) begin
            if (!PRESETn) begin
                r_mb_id   <= '0;
                r_mb_data <= '0;
                r_mb_dlc  <= '0;
                r_mb_fmt  <= 1'b0;
                r_mb_ft   <= '0;
                r_pend    <= 1'b0;
            end else if (w_load_hit) begin
                r_mb_id   <= mb_id;
                r_mb_data <= mb_data;
                r_mb_dlc  <= mb_datalen;
                r_mb_fmt  <= mb_format;
                r_mb_ft   <= mb_frametype;
                r_pend    <= 1'b1;
            end else if (w_finish_hit || w_abort_hit) begin
                r_pend    <= 1'b0;
            end
        end

        assign w_mb_id[gi]   = r_mb_id;
        assign w_mb_data[gi] = r_mb_data;
        assign w_mb_dlc[gi]  = r_mb_dlc;
        assign w_mb_fmt[gi]  = r_mb_fmt;
        assign w_mb_ft[gi]   = r_mb_ft;
        assign w_pending[gi] = r_pend;
        // Standard frames ignore the extended id bits when ranking
        assign w_key[gi]     = {r_mb_id[28:18], r_mb_fmt,
                                r_mb_fmt ? r_mb_id[17:0] : 18'd0};
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state      <= c_S_IDLE;
            r_cnt        <= '0;
            r_tx_idx     <= '0;
            r_start      <= 1'b0;
            r_xmitdata   <= '0;
            r_id         <= '0;
            r_datalen    <= '0;
            r_format     <= 1'b0;
            r_frametype  <= '0;
            r_quantadiv  <= '0;
            r_propquanta <= '0;
            r_seg1quanta <= '0;
            r_load_rej   <= 1'b0;
            r_tx_done    <= 1'b0;
            r_tx_err     <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
            r_load_rej <= mb_load && w_sel_flight;
            case (r_state)
                c_S_IDLE: begin
                    if (|w_pending) r_state <= c_S_ARB;
                end
                c_S_ARB: begin
                    // Pending can vanish between IDLE and ARB through abort
                    if (w_found) begin
                        r_tx_idx     <= w_win_idx;
                        r_xmitdata   <= w_mb_data[w_win_idx];
                        r_id         <= w_mb_id[w_win_idx];
                        r_datalen    <= w_mb_dlc[w_win_idx];
                        r_format     <= w_mb_fmt[w_win_idx];
                        r_frametype  <= w_mb_ft[w_win_idx];
                        r_quantadiv  <= bit_cfg[19:12];
                        r_propquanta <= bit_cfg[11:6];
                        r_seg1quanta <= bit_cfg[5:0];
                        r_start      <= 1'b1;
                        r_state      <= c_S_START;
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end
                c_S_START: begin
                    r_cnt   <= '0;
                    r_state <= c_S_WAIT_BUSY;
                end
                c_S_WAIT_BUSY: begin
                    if (busy) begin
                        r_state <= c_S_WAIT_DONE;
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_tx_err <= 1'b1;
                        r_state  <= c_S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_S_WAIT_DONE: begin
                    if (!busy) begin
                        r_tx_done <= 1'b1;
                        r_state   <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign startXmit  = r_start;
    assign xmitdata   = r_xmitdata;
    assign id         = r_id;
    assign datalen    = r_datalen;
    assign format     = r_format;
    assign frameType  = r_frametype;
    assign quantaDiv  = r_quantadiv;
    assign propQuanta = r_propquanta;
    assign seg1Quanta = r_seg1quanta;
    assign mb_pending = w_pending;
    assign load_rej   = r_load_rej;
    assign tx_done    = r_tx_done;
    assign tx_err     = r_tx_err;
    assign tx_idx     = r_tx_idx;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_tx_scheduler
// Purpose  : Directed self-checking bench for can_tx_scheduler. A second
//            instance with BUSY_TIMEOUT=4 and busy tied low covers timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_tx_scheduler;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        mb_load;
    logic [1:0]  mb_sel;
    logic [28:0] mb_id;
    logic [63:0] mb_data;
    logic [3:0]  mb_datalen;
    logic        mb_format;
    logic [1:0]  mb_frametype;
    logic [3:0]  mb_abort;
    logic [19:0] bit_cfg;
    logic        busy;
    logic        busy_to;

    logic        startXmit,   startXmit_to;
    logic [63:0] xmitdata,    xmitdata_to;
    logic [28:0] id,          id_to;
    logic [3:0]  datalen,     datalen_to;
    logic        format,      format_to;
    logic [1:0]  frameType,   frameType_to;
    logic [7:0]  quantaDiv,   quantaDiv_to;
    logic [5:0]  propQuanta,  propQuanta_to;
    logic [5:0]  seg1Quanta,  seg1Quanta_to;
    logic [3:0]  mb_pending,  mb_pending_to;
    logic        load_rej,    load_rej_to;
    logic        tx_done,     tx_done_to;
    logic        tx_err,      tx_err_to;
    logic [1:0]  tx_idx,      tx_idx_to;

    int n_checks = 0;
    int n_errors = 0;

    always #5 PCLK = ~PCLK;

    can_tx_scheduler #(.NUM_MB(4), .BUSY_TIMEOUT(255)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .mb_load(mb_load), .mb_sel(mb_sel),
        .mb_id(mb_id), .mb_data(mb_data), .mb_datalen(mb_datalen),
        .mb_format(mb_format), .mb_frametype(mb_frametype), .mb_abort(mb_abort),
        .bit_cfg(bit_cfg), .busy(busy), .startXmit(startXmit),
        .xmitdata(xmitdata), .id(id), .datalen(datalen), .format(format),
        .frameType(frameType), .quantaDiv(quantaDiv), .propQuanta(propQuanta),
        .seg1Quanta(seg1Quanta), .mb_pending(mb_pending), .load_rej(load_rej),
        .tx_done(tx_done), .tx_err(tx_err), .tx_idx(tx_idx)
    );

    can_tx_scheduler #(.NUM_MB(4), .BUSY_TIMEOUT(4)) dut_to (
        .PCLK(PCLK), .PRESETn(PRESETn), .mb_load(mb_load), .mb_sel(mb_sel),
        .mb_id(mb_id), .mb_data(mb_data), .mb_datalen(mb_datalen),
        .mb_format(mb_format), .mb_frametype(mb_frametype), .mb_abort(mb_abort),
        .bit_cfg(bit_cfg), .busy(busy_to), .startXmit(startXmit_to),
        .xmitdata(xmitdata_to), .id(id_to), .datalen(datalen_to),
        .format(format_to), .frameType(frameType_to), .quantaDiv(quantaDiv_to),
        .propQuanta(propQuanta_to), .seg1Quanta(seg1Quanta_to),
        .mb_pending(mb_pending_to), .load_rej(load_rej_to),
        .tx_done(tx_done_to), .tx_err(tx_err_to), .tx_idx(tx_idx_to)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic load_mb(input logic [1:0] sel, input logic [28:0] fid,
                           input logic [63:0] dat, input logic [3:0] dlc,
                           input logic fmt);
        mb_load      = 1'b1;
        mb_sel       = sel;
        mb_id        = fid;
        mb_data      = dat;
        mb_datalen   = dlc;
        mb_format    = fmt;
        mb_frametype = 2'b01;
        tick();
        mb_load      = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (startXmit !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        check({tag, " startXmit"}, startXmit, 1);
    endtask

    // Entered in the START cycle; busy rises two cycles later for blen cycles
    task automatic finish_frame(input string tag, input logic [1:0] idx, input int blen);
        tick();
        tick();
        busy = 1'b1;
        repeat (blen) tick();
        busy = 1'b0;
        tick();
        check({tag, " tx_done"}, tx_done, 1);
        check({tag, " tx_idx"}, tx_idx, idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn      = 1'b0;
        mb_load      = 1'b1;
        mb_sel       = 2'd1;
        mb_id        = 29'h1ABCDEF0;
        mb_data      = 64'hDEADBEEF_CAFEF00D;
        mb_datalen   = 4'd8;
        mb_format    = 1'b1;
        mb_frametype = 2'b11;
        mb_abort     = 4'b0000;
        bit_cfg      = {8'h0A, 6'd5, 6'd7};
        busy         = 1'b1;
        busy_to      = 1'b1;

        // ---------------- reset ----------------
        repeat (3) tick();
        check("rst startXmit", startXmit, 0);
        check("rst pending", mb_pending, 0);
        check("rst id", id, 0);
        check("rst xmitdata", xmitdata, 0);
        check("rst tx_idx", tx_idx, 0);
        check("rst flags", {load_rej, tx_done, tx_err}, 0);
        check("rst quantaDiv", quantaDiv, 0);
        check("rst pending_to", mb_pending_to, 0);
        PRESETn = 1'b1;
        mb_load = 1'b0;
        busy    = 1'b0;
        busy_to = 1'b0;
        tick();
        check("rel pending", mb_pending, 0);
        check("rel startXmit", startXmit, 0);

        // ---------------- single frame (and timeout on dut_to) ----------------
        load_mb(2'd2, 29'h048C0000, 64'h11223344_55667788, 4'd8, 1'b0);  // E0
        check("sf pending E0", mb_pending, 4'b0100);
        check("sf start E0", startXmit, 0);
        tick();  // E1: ARB
        check("sf start E1", startXmit, 0);
        tick();  // E2: START
        check("sf start E2", startXmit, 1);
        check("sf id", id, 29'h048C0000);
        check("sf data", xmitdata, 64'h11223344_55667788);
        check("sf dlc", datalen, 8);
        check("sf format", format, 0);
        check("sf frameType", frameType, 2'b01);
        check("sf tx_idx", tx_idx, 2);
        check("sf bitcfg", {quantaDiv, propQuanta, seg1Quanta}, {8'h0A, 6'd5, 6'd7});
        check("to start E2", startXmit_to, 1);
        tick();  // E3
        check("sf start E3", startXmit, 0);
        repeat (4) tick();  // E7
        check("to no err E7", tx_err_to, 0);
        busy = 1'b1;
        tick();  // E8
        check("to tx_err", tx_err_to, 1);
        check("to tx_idx", tx_idx_to, 2);
        check("to pending", mb_pending_to, 0);
        check("to no done", tx_done_to, 0);
        check("sf no err", tx_err, 0);
        repeat (99) tick();
        check("sf busy no done", tx_done, 0);
        busy = 1'b0;
        tick();
        check("sf tx_done", tx_done, 1);
        check("sf done idx", tx_idx, 2);
        check("sf pending", mb_pending, 0);
        tick();
        check("sf done pulse", tx_done, 0);
        check("to err pulse", tx_err_to, 0);

        // ---------------- priority ----------------
        load_mb(2'd0, 29'h08000000, 64'h0000_0000_0000_00A0, 4'd4, 1'b0);
        load_mb(2'd1, 29'h04000000, 64'h0000_0000_0000_00A1, 4'd2, 1'b0);
        load_mb(2'd3, 29'h04000005, 64'h0000_0000_0000_00A3, 4'd6, 1'b1);
        check("pri pending", mb_pending, 4'b1011);
        wait_start("pri1");
        check("pri1 idx", tx_idx, 1);
        check("pri1 id", id, 29'h04000000);
        finish_frame("pri1", 2'd1, 10);
        check("pri1 pending", mb_pending, 4'b1001);
        wait_start("pri2");
        check("pri2 idx", tx_idx, 3);
        check("pri2 id", id, 29'h04000005);
        check("pri2 format", format, 1);
        check("pri2 dlc", datalen, 6);
        finish_frame("pri2", 2'd3, 10);
        wait_start("pri3");
        check("pri3 idx", tx_idx, 0);
        check("pri3 data", xmitdata, 64'h0000_0000_0000_00A0);
        finish_frame("pri3", 2'd0, 10);
        check("pri pending end", mb_pending, 0);

        // ---------------- collision ----------------
        load_mb(2'd1, 29'h00400000, 64'hAAAA_AAAA_AAAA_AAAA, 4'd8, 1'b0);
        wait_start("col");
        tick();
        tick();
        busy = 1'b1;
        tick();
        tick();  // WAIT_DONE
        load_mb(2'd1, 29'h00400000, 64'hBBBB_BBBB_BBBB_BBBB, 4'd8, 1'b0);
        check("col load_rej", load_rej, 1);
        check("col pending rej", mb_pending, 4'b0010);
        load_mb(2'd0, 29'h00000001, 64'hCCCC_CCCC_CCCC_CCCC, 4'd8, 1'b0);
        check("col load_rej mb0", load_rej, 0);
        check("col pending mb0", mb_pending, 4'b0011);
        busy = 1'b0;
        tick();
        check("col done", tx_done, 1);
        check("col done idx", tx_idx, 1);
        check("col data kept", xmitdata, 64'hAAAA_AAAA_AAAA_AAAA);
        check("col pending done", mb_pending, 4'b0001);
        wait_start("col2");
        check("col2 idx", tx_idx, 0);
        check("col2 data", xmitdata, 64'hCCCC_CCCC_CCCC_CCCC);
        // load into mb0 in the very cycle its completion is decided
        tick();
        tick();
        busy = 1'b1;
        repeat (3) tick();
        busy         = 1'b0;
        mb_load      = 1'b1;
        mb_sel       = 2'd0;
        mb_data      = 64'hDDDD_DDDD_DDDD_DDDD;
        tick();
        mb_load = 1'b0;
        check("same-cycle done", tx_done, 1);
        check("same-cycle rej", load_rej, 1);
        check("same-cycle pending", mb_pending, 0);
        repeat (5) tick();
        check("same-cycle idle", mb_pending, 0);

        // ---------------- abort ----------------
        load_mb(2'd2, 29'h00100000, 64'hE2, 4'd1, 1'b0);
        load_mb(2'd3, 29'h00200000, 64'hE3, 4'd1, 1'b0);
        wait_start("abt");
        check("abt idx", tx_idx, 2);
        mb_abort = 4'b1100;
        tick();
        mb_abort = 4'b0000;
`ifdef CAN_SCHED_ABORT_EN
        check("abt pending", mb_pending, 4'b0100);
`else
        check("abt pending", mb_pending, 4'b1100);
`endif
        finish_frame("abt", 2'd2, 5);
`ifdef CAN_SCHED_ABORT_EN
        check("abt pending done", mb_pending, 4'b0000);
        repeat (5) tick();
        check("abt no start", startXmit, 0);
`else
        check("abt pending done", mb_pending, 4'b1000);
        wait_start("abt3");
        check("abt3 idx", tx_idx, 3);
        finish_frame("abt3", 2'd3, 5);
`endif
        // abort and load on the same idle mailbox: load wins
        mb_abort = 4'b1000;
        load_mb(2'd3, 29'h00300000, 64'hF3, 4'd2, 1'b0);
        mb_abort = 4'b0000;
        check("abt+load pending", mb_pending, 4'b1000);
        wait_start("abt+load");
        check("abt+load idx", tx_idx, 3);
        finish_frame("abt+load", 2'd3, 5);

        // ---------------- reset mid-frame ----------------
        load_mb(2'd0, 29'h00100000, 64'h10, 4'd1, 1'b0);
        load_mb(2'd1, 29'h00200000, 64'h11, 4'd1, 1'b0);
        wait_start("mr");
        tick();
        tick();
        busy = 1'b1;
        tick();
        tick();  // WAIT_DONE
        PRESETn = 1'b0;
        tick();
        check("mr pending", mb_pending, 0);
        check("mr start", startXmit, 0);
        check("mr tx_idx", tx_idx, 0);
        PRESETn = 1'b1;
        busy    = 1'b0;
        tick();
        check("mr no done", {tx_done, tx_err}, 0);
        repeat (3) tick();
        check("mr idle start", startXmit, 0);
        check("mr idle pending", mb_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
